// File: rtl/clk_inp_capture_if.sv
// Bundle of the sample-side and result-side signals of clk_inp_capture.
// The master modport drives samples; the slave modport is the capture stage.
`timescale 1ns/1ps
interface clk_inp_capture_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 8
);
    logic                      in_valid;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic                      invert;
    logic [CHANNELS-1:0]       ch_en;
    logic                      clear;
    logic                      out_valid;
    logic [CHANNELS*WIDTH-1:0] out_data;
    logic [CHANNELS-1:0]       mismatch;
    logic [CHANNELS*CNT_W-1:0] mismatch_cnt;

    modport master (
        output in_valid, in_data, invert, ch_en, clear,
        input  out_valid, out_data, mismatch, mismatch_cnt
    );

    modport slave (
        input  in_valid, in_data, invert, ch_en, clear,
        output out_valid, out_data, mismatch, mismatch_cnt
    );
endinterface

// File: rtl/clk_inp_capture.sv
// Multi-lane input capture over two paths (in-process and combinational),
// with per-lane divergence detection and a STAGES-deep valid pipeline.
`timescale 1ns/1ps
module clk_inp_capture #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    parameter int STAGES   = 2,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    clk_inp_capture_if.slave  bus
);
    typedef logic [CHANNELS-1:0][WIDTH-1:0] lanes_t;

    // pipe_reg[0] is the path-A capture register itself.
    lanes_t            pipe_reg [STAGES];
    lanes_t            capb_reg;
    lanes_t            a_comb;
    logic [STAGES-1:0] vld_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_reg  <= '0;
            capb_reg <= '0;
            for (int s = 0; s < STAGES; s++) begin
                pipe_reg[s] <= '0;
            end
        end else begin
            vld_reg[0] <= bus.in_valid;
            for (int c = 0; c < CHANNELS; c++) begin
                if (bus.in_valid && bus.ch_en[c]) begin
                    pipe_reg[0][c] <= bus.invert ? ~bus.in_data[c*WIDTH +: WIDTH]
                                                 :  bus.in_data[c*WIDTH +: WIDTH];
                    capb_reg[c]    <= a_comb[c];
                end
            end
            for (int s = 1; s < STAGES; s++) begin
                vld_reg[s] <= vld_reg[s-1];
                if (vld_reg[s-1]) begin
                    pipe_reg[s] <= pipe_reg[s-1];
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
            logic [CNT_W-1:0] cnt_reg;
            logic             flag_reg;
            logic             diff;

            assign a_comb[gi] = bus.invert ? ~bus.in_data[gi*WIDTH +: WIDTH]
                                           :  bus.in_data[gi*WIDTH +: WIDTH];
            assign diff = vld_reg[0] && (pipe_reg[0][gi] != capb_reg[gi]);

            // Clear takes priority over a divergence seen on the same edge.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg  <= '0;
                    flag_reg <= 1'b0;
                end else if (bus.clear) begin
                    cnt_reg  <= '0;
                    flag_reg <= 1'b0;
                end else if (diff) begin
                    flag_reg <= 1'b1;
                    if (cnt_reg != {CNT_W{1'b1}}) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign bus.mismatch[gi]                   = flag_reg;
            assign bus.mismatch_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
        end
    endgenerate

    assign bus.out_valid = vld_reg[STAGES-1];
    assign bus.out_data  = pipe_reg[STAGES-1];
endmodule

// File: tb/tb_clk_inp_capture.sv
// Self-checking bench for clk_inp_capture: directed vector table, reset and
// fault-injection sequences, and same-timestep random stimulus vs a queue model.
`timescale 1ns/1ps
module tb_clk_inp_capture;
    localparam int W = 8;
    localparam int C = 2;
    localparam int S = 2;
    localparam int N = 8;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    clk_inp_capture_if #(.WIDTH(W), .CHANNELS(C), .CNT_W(N)) bus ();

    clk_inp_capture #(.WIDTH(W), .CHANNELS(C), .STAGES(S), .CNT_W(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference model: samples flow through a queue of depth S-1; the lane
    // image seen downstream only advances when a valid sample leaves the queue.
    typedef struct {
        logic        v;
        logic [15:0] d;
    } ent_t;
    ent_t        m_q[$];
    logic [15:0] m_cap;
    logic        m_ov;
    logic [15:0] m_od;

    task automatic model_reset();
        m_q.delete();
        m_cap = '0;
        m_ov  = 1'b0;
        m_od  = '0;
    endtask

    task automatic model_edge(input logic v, input logic inv, input logic [1:0] en,
                              input logic [15:0] d);
        ent_t e;
        logic [15:0] f;
        f = inv ? ~d : d;
        if (v) begin
            if (en[0]) m_cap[7:0]  = f[7:0];
            if (en[1]) m_cap[15:8] = f[15:8];
        end
        e.v = v;
        e.d = m_cap;
        m_q.push_back(e);
        if (m_q.size() > S - 1) begin
            e    = m_q.pop_front();
            m_ov = e.v;
            if (e.v) m_od = e.d;
        end
    endtask

    typedef struct {
        logic        v;
        logic        inv;
        logic [1:0]  en;
        logic [15:0] d;
        logic        ev;
        logic [15:0] ed;
    } vec_t;
    vec_t tbl[13];

    task automatic drive(input logic v, input logic inv, input logic [1:0] en,
                         input logic [15:0] d);
        bus.in_valid = v;
        bus.invert   = inv;
        bus.ch_en    = en;
        bus.in_data  = d;
    endtask

    task automatic check_mm(input string name, input logic [1:0] emm, input logic [15:0] ecnt);
        check({name, "_flag"}, 64'(bus.mismatch), 64'(emm));
        check({name, "_cnt"}, 64'(bus.mismatch_cnt), 64'(ecnt));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model_reset();
        rst_n     = 1'b0;
        bus.clear = 1'b0;
        drive(1'b0, 1'b0, 2'b11, 16'h0000);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check_mm("rst_mm", 2'b00, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        tbl[0]  = '{1'b1, 1'b1, 2'b11, 16'h5AC3, 1'b0, 16'h0000};
        tbl[1]  = '{1'b0, 1'b0, 2'b11, 16'h0000, 1'b1, 16'hA53C};
        tbl[2]  = '{1'b0, 1'b0, 2'b11, 16'h0000, 1'b0, 16'hA53C};
        tbl[3]  = '{1'b1, 1'b0, 2'b11, 16'h0001, 1'b0, 16'hA53C};
        tbl[4]  = '{1'b1, 1'b0, 2'b11, 16'h0002, 1'b1, 16'h0001};
        tbl[5]  = '{1'b1, 1'b1, 2'b11, 16'h0003, 1'b1, 16'h0002};
        tbl[6]  = '{1'b1, 1'b0, 2'b11, 16'h0004, 1'b1, 16'hFFFC};
        tbl[7]  = '{1'b0, 1'b0, 2'b11, 16'h0000, 1'b1, 16'h0004};
        tbl[8]  = '{1'b0, 1'b0, 2'b11, 16'h0000, 1'b0, 16'h0004};
        tbl[9]  = '{1'b1, 1'b0, 2'b11, 16'h7722, 1'b0, 16'h0004};
        tbl[10] = '{1'b1, 1'b0, 2'b01, 16'h1111, 1'b1, 16'h7722};
        tbl[11] = '{1'b0, 1'b0, 2'b11, 16'h0000, 1'b1, 16'h7711};
        tbl[12] = '{1'b0, 1'b0, 2'b11, 16'h0000, 1'b0, 16'h7711};

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].inv, tbl[i].en, tbl[i].d);
            @(posedge clk);
            #1;
            $display("vec %0d: in v=%0b inv=%0b en=%b d=%h -> out v=%0b d=%h",
                     i, tbl[i].v, tbl[i].inv, tbl[i].en, tbl[i].d, bus.out_valid, bus.out_data);
            check($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'(tbl[i].ev));
            check($sformatf("vec%0d_data", i), 64'(bus.out_data), 64'(tbl[i].ed));
        end
        check_mm("vec_mm", 2'b00, 16'h0000);

        // Reset mid-cycle with the pipeline full
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 2'b11, 16'h1357 + 16'(i));
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_out_data", 64'(bus.out_data), 64'd0);
        check_mm("midrst_mm", 2'b00, 16'h0000);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b11, 16'h0000);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            $display("post-reset cycle %0d: out v=%0b d=%h", i, bus.out_valid, bus.out_data);
            check($sformatf("postrst%0d_valid", i), 64'(bus.out_valid), 64'd0);
            check($sformatf("postrst%0d_data", i), 64'(bus.out_data), 64'd0);
        end
        model_reset();

        // Same-timestep random stimulus: inputs updated by NBA on the rising edge
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            model_edge(bus.in_valid, bus.invert, bus.ch_en, bus.in_data);
            bus.in_valid <= 1'($urandom_range(0, 3) != 0);
            bus.invert   <= 1'($urandom);
            bus.ch_en    <= 2'($urandom);
            bus.in_data  <= 16'($urandom);
            #1;
            $display("rand %0d: out v=%0b d=%h model v=%0b d=%h",
                     i, bus.out_valid, bus.out_data, m_ov, m_od);
            check($sformatf("rand%0d_valid", i), 64'(bus.out_valid), 64'(m_ov));
            check($sformatf("rand%0d_data", i), 64'(bus.out_data), 64'(m_od));
        end
        check_mm("rand_mm", 2'b00, 16'h0000);

        // Fault injection on lane 1's path-B register
        @(negedge clk);
        drive(1'b1, 1'b0, 2'b11, 16'h1234);
        @(posedge clk);
        @(negedge clk);
        force dut.capb_reg = 16'hED34;
        @(posedge clk);
        #1;
        $display("fault edge 1: mismatch=%b cnt=%h", bus.mismatch, bus.mismatch_cnt);
        check_mm("fault_first", 2'b10, 16'h0100);
        repeat (299) @(posedge clk);
        #1;
        $display("fault edge 300: mismatch=%b cnt=%h", bus.mismatch, bus.mismatch_cnt);
        check_mm("fault_sat", 2'b10, 16'hFF00);
        @(negedge clk);
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        $display("clear during fault: mismatch=%b cnt=%h", bus.mismatch, bus.mismatch_cnt);
        check_mm("fault_clear", 2'b00, 16'h0000);
        @(negedge clk);
        release dut.capb_reg;
        @(posedge clk);
        #1;
        check_mm("release_clear", 2'b00, 16'h0000);
        @(negedge clk);
        bus.clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("after release: mismatch=%b cnt=%h", bus.mismatch, bus.mismatch_cnt);
        check_mm("after_release", 2'b00, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
